// File: rtl/bitstream_decode_array.sv
// Stochastic-to-binary decoder array: counts ones per lane over 2^RWID enabled cycles.
// Optional macro BIPOLAR_EN selects bipolar (2*count - 2^RWID) output mapping.
module bitstream_decode_array #(
  parameter int RWID = 8,
  parameter int BDIM = 2,
  parameter int SDIM = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [BDIM*SDIM-1:0] bsIn,
  output logic [RWID:0]        binOut [BDIM*SDIM-1:0],
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 overrun
);

  localparam int LANES = BDIM * SDIM;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t          state;
  logic [RWID-1:0] win_cnt;
  logic [RWID:0]   acc [LANES-1:0];
  logic            acc_en;
  logic            win_end;
  logic            accept;

  assign acc_en  = enable & ~clear;
  assign win_end = acc_en & (win_cnt == {RWID{1'b1}});
  assign accept  = outValid & outReady;

  // Bipolar +2^RWID does not fit RWID+1 signed bits, so it clamps to the largest positive code.
  function automatic logic [RWID:0] map_count(input logic [RWID:0] cnt);
`ifdef BIPOLAR_EN
    logic signed [RWID+2:0] bip;
    bip = $signed({1'b0, cnt, 1'b0}) - $signed({3'b001, {RWID{1'b0}}});
    if (bip > $signed({3'b000, {RWID{1'b1}}}))
      return {1'b0, {RWID{1'b1}}};
    return bip[RWID:0];
`else
    return cnt;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      win_cnt  <= '0;
      outValid <= 1'b0;
      overrun  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        acc[i]    <= '0;
        binOut[i] <= '0;
      end
    end else begin
      // Window accumulation: clear restarts the window and discards this cycle's bits
      if (clear) begin
        state   <= IDLE;
        win_cnt <= '0;
        for (int i = 0; i < LANES; i++) acc[i] <= '0;
      end else begin
        case (state)
          IDLE:    if (enable)  state <= ACC;
          ACC:     if (!enable) state <= HOLD;
          HOLD:    if (enable)  state <= ACC;
          default: state <= IDLE;
        endcase
        if (enable) begin
          win_cnt <= win_cnt + RWID'(1);
          for (int i = 0; i < LANES; i++)
            acc[i] <= win_end ? '0 : acc[i] + {{RWID{1'b0}}, bsIn[i]};
        end
      end

      // Output handshake: the final bit of the window is folded in on the same edge
      if (win_end) begin
        for (int i = 0; i < LANES; i++)
          binOut[i] <= map_count(acc[i] + {{RWID{1'b0}}, bsIn[i]});
        outValid <= 1'b1;
        if (outValid && !outReady) overrun <= 1'b1;
      end else if (accept) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitstream_decode_array.sv
// Randomized self-checking bench for bitstream_decode_array against a window-count model.
module tb_bitstream_decode_array;

  localparam int LANES = 16;
  localparam int WIN   = 256;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             clear;
  logic [LANES-1:0] bsIn;
  logic [8:0]       binOut [LANES-1:0];
  logic             outValid;
  logic             outReady;
  logic             overrun;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int m_sum [LANES];
  int m_bin [LANES];
  int m_ncyc;
  bit m_valid;
  bit m_ovr;

  bitstream_decode_array #(.RWID(8), .BDIM(2), .SDIM(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .bsIn(bsIn),
    .binOut(binOut), .outValid(outValid), .outReady(outReady), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int exp_map(input int c);
`ifdef BIPOLAR_EN
    int v;
    v = 2 * c - WIN;
    return (v > WIN - 1) ? WIN - 1 : v;
`else
    return c;
`endif
  endfunction

  function automatic int lane_val(input int i);
`ifdef BIPOLAR_EN
    return int'($signed(binOut[i]));
`else
    return int'(binOut[i]);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_sum[i] = 0;
      m_bin[i] = 0;
    end
    m_ncyc  = 0;
    m_valid = 0;
    m_ovr   = 0;
  endtask

  // One clock of the reference: a window is simply WIN enabled, non-cleared cycles.
  task automatic model_step(input bit en, input bit clr, input logic [LANES-1:0] bs, input bit rdy);
    bit accept;
    accept = m_valid && rdy;
    if (clr) begin
      for (int i = 0; i < LANES; i++) m_sum[i] = 0;
      m_ncyc = 0;
      if (accept) m_valid = 0;
    end else if (!en) begin
      if (accept) m_valid = 0;
    end else begin
      for (int i = 0; i < LANES; i++) m_sum[i] += int'(bs[i]);
      m_ncyc++;
      if (m_ncyc == WIN) begin
        for (int i = 0; i < LANES; i++) begin
          m_bin[i] = exp_map(m_sum[i]);
          m_sum[i] = 0;
        end
        m_ncyc = 0;
        if (m_valid && !rdy) m_ovr = 1;
        m_valid = 1;
      end else if (accept) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic compare_outputs(input string tag);
    check_val({tag, "_valid"}, int'(outValid), int'(m_valid));
    check_val({tag, "_overrun"}, int'(overrun), int'(m_ovr));
    if (m_valid)
      for (int i = 0; i < LANES; i++)
        check_val($sformatf("%s_bin%0d", tag, i), lane_val(i), m_bin[i]);
  endtask

  task automatic step(input string tag, input bit en, input bit clr,
                      input logic [LANES-1:0] bs, input bit rdy);
    enable   = en;
    clear    = clr;
    bsIn     = bs;
    outReady = rdy;
    @(posedge clk);
    model_step(en, clr, bs, rdy);
    #1;
    compare_outputs(tag);
  endtask

  initial begin
    logic [LANES-1:0] bs;
    int r;
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; bsIn = '0; outReady = 1'b0;
    model_reset();
    #12;
    check_val("rst_valid", int'(outValid), 0);
    check_val("rst_overrun", int'(overrun), 0);
    check_val("rst_bin0", int'(binOut[0]), 0);
    check_val("rst_bin15", int'(binOut[15]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // all-ones full window, always ready
    for (int k = 0; k < WIN - 1; k++) step("ones", 1, 0, '1, 1);
    check_val("ones_pre_valid", int'(outValid), 0);
    step("ones", 1, 0, '1, 1);
    check_val("ones_valid", int'(outValid), 1);
    check_val("ones_bin0", lane_val(0), exp_map(256));
    check_val("ones_bin15", lane_val(15), exp_map(256));
    step("ones_ack", 1, 0, '0, 1);
    check_val("ones_ack_valid", int'(outValid), 0);

    // full-period RNG comparison: lane i must decode to exactly i*16
    for (int k = 0; k < WIN - 1; k++) step("pad", 1, 0, '0, 1);
    for (int k = 0; k < WIN; k++) begin
      r = (k * 167 + 13) % WIN;
      for (int i = 0; i < LANES; i++) bs[i] = (i * 16 > r);
      step("rng", 1, 0, bs, 0);
    end
    for (int i = 0; i < LANES; i++)
      check_val($sformatf("rng_lane%0d", i), lane_val(i), exp_map(i * 16));

    // enable gap of 50 cycles after window cycle 100
    for (int k = 0; k < 101; k++) step("gap", 1, 0, '1, 1);
    for (int k = 0; k < 50; k++) step("gap_hold", 0, 0, $urandom, 1);
    for (int k = 0; k < 155; k++) step("gap", 1, 0, '1, 1);
    check_val("gap_valid", int'(outValid), 1);
    check_val("gap_bin7", lane_val(7), exp_map(256));

    // two window ends with no acceptance
    for (int k = 0; k < 2 * WIN; k++) step("ovr", 1, 0, $urandom, 0);
    check_val("ovr_flag", int'(overrun), 1);
    for (int k = 0; k < 20; k++) step("ovr_after", 1, 0, $urandom, 1);
    check_val("ovr_sticky", int'(overrun), 1);

    // clear at window cycle 200: old boundary passes silently
    for (int k = 0; k < WIN - 20; k++) step("pre_clr", 1, 0, $urandom, 1);
    for (int k = 0; k < 200; k++) step("clr_a", 1, 0, '1, 1);
    step("clr", 1, 1, '1, 1);
    for (int k = 0; k < WIN - 1; k++) step("clr_b", 1, 0, '1, 1);
    check_val("clr_no_early", int'(outValid), 0);
    step("clr_b", 1, 0, '1, 1);
    check_val("clr_valid", int'(outValid), 1);
    check_val("clr_bin3", lane_val(3), exp_map(256));

    // randomized traffic with sparse enables, clears and back-pressure
    for (int k = 0; k < 3000; k++)
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0,
           $urandom, $urandom_range(0, 3) != 0);

    // asynchronous reset in the middle of a window
    clear = 1'b0;
    step("sync_ack", 1, 1, '1, 1);
    for (int k = 0; k < 128; k++) step("mid", 1, 0, '1, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("arst_valid", int'(outValid), 0);
    check_val("arst_overrun", int'(overrun), 0);
    check_val("arst_bin0", int'(binOut[0]), 0);
    check_val("arst_bin9", int'(binOut[9]), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < WIN; k++) step("post", 1, 0, '1, 1);
    check_val("post_valid", int'(outValid), 1);
    check_val("post_bin12", lane_val(12), exp_map(256));
    check_val("post_overrun", int'(overrun), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
